window_scan_ctrl: RTL and testbench
===================================

// Module: window_scan_ctrl
// PURPOSE
//  Raster-scan sequencer for the 7x7 line-memory window (MAU) datapath.
//  Accepts a valid/ready pixel stream, drives the window's shift enable, tracks row/col
//  position and issues a window-valid handshake only when a full interior 7x7 window is present.
//  Sits between pixel source and MAU; downstream pattern matcher consumes m_valid/center coords.
// PARAMETERS
//  IMG_W   640  pixels per line (MAU line memories sized IMG_W-7)
//  IMG_H   480  lines per frame
//  WIN     7    window edge; centre offset = WIN/2 = 3
//  CW      10   column counter width, 2**CW >= IMG_W
//  RW      10   row counter width, 2**RW >= IMG_H
//  WIN_LAT 2    cycles from shift edge to MAU window outputs stable (>=1)
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-high reset
//  s_valid     in   1   pixel available
//  s_ready     out  1   pixel accepted when s_valid&&s_ready
//  s_sof       in   1   qualifies pixel (0,0) of a frame
//  shift_en    out  1   = s_valid&&s_ready; drives MAU data_enable (combinational)
//  m_valid     out  1   MAU window/data_out valid for center_row/center_col
//  m_ready     in   1   consumer accepts window
//  center_row  out  RW  row of window centre
//  center_col  out  CW  column of window centre
//  frame_done  out  1   1-cycle pulse after last window of frame accepted
//  busy        out  1   state != IDLE
//  sof_err     out  1   1-cycle pulse, s_sof seen mid-frame (WSC_ERR_CHECK_EN only; else 0)
// BEHAVIOUR
//  Reset: state=IDLE, row=col=0, vld_pipe=0, m_valid=0, center_*=0, frame_done=0, sof_err=0.
//  FSM IDLE: s_ready=1; pixels without s_sof dropped (accepted, no shift_en). Pixel with s_sof
//   -> shift, row=0,col=1, go RUN.
//  FSM RUN: each accepted pixel at (r,c) shifts; col++ ; col==IMG_W-1 -> col=0,row++.
//   Accepted pixel with r>=WIN-1 && c>=WIN-1 is window-producing: loads vld_pipe, captures
//   center=(r-3,c-3). After WIN_LAT clock edges m_valid=1, held with stable centre until m_ready.
//   Pixel (IMG_H-1,IMG_W-1) accepted -> go DRAIN.
//  FSM DRAIN: s_ready=0; when last window handshakes -> frame_done=1 one cycle, go IDLE.
//  Backpressure: s_ready=0 while any vld_pipe stage set or (m_valid&&!m_ready); MAU cells must not
//   shift under a pending window. m_valid&&m_ready in same cycle as new accept is legal.
//   Interior throughput therefore 1 window per WIN_LAT cycles; border pixels 1/cycle.
//  Windows per frame = (IMG_W-6)*(IMG_H-6); no border/partial windows emitted.
//  s_valid low: no shift, counters hold. m_ready ignored when m_valid=0.
//  Reset mid-frame: immediate return to IDLE, pending window discarded; MAU contents stale but
//   unused until 6 full lines of next frame shifted.
// CONFIGURATION
//  WSC_ERR_CHECK_EN defined: s_sof on accepted pixel in RUN -> sof_err pulse, pending window
//   dropped (m_valid cleared), pixel treated as (0,0) of new frame (row=0,col=1).
//  Not defined: s_sof ignored outside IDLE, sof_err tied 0, no extra logic.
// TESTING (bench IMG_W=16, IMG_H=10, WIN_LAT=2)
//  1 Reset then continuous frame, m_ready=1 -> exactly 40 windows; first center (3,3) after pixel
//    (6,6); last center (6,12); frame_done one pulse; busy low after.
//  2 Pixels without s_sof in IDLE -> shift_en stays 0, m_valid 0, state IDLE.
//  3 m_ready=0 for 5 cycles on first window -> m_valid and center (3,3) held, s_ready=0, no shift_en.
//  4 Random s_valid gaps -> window count 40, centres in raster order, no duplicates/skips.
//  5 Reset asserted at pixel (7,8) -> all outputs reset values next edge; new frame gives 40 windows.
//  6 WSC_ERR_CHECK_EN: s_sof at pixel (4,5) -> sof_err pulse, next frame-relative first center (3,3)
//    after 6 lines + 7 pixels; without macro -> s_sof ignored, 40 windows of original frame.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the 7x7 MAU window: pixel handshake, row/col, window valid.
// Optional WSC_ERR_CHECK_EN: s_sof mid-frame restarts the frame and pulses sof_err.
module window_scan_ctrl #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int WIN     = 7,
  parameter int CW      = 10,
  parameter int RW      = 10,
  parameter int WIN_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  output logic          shift_en,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [RW-1:0] center_row,
  output logic [CW-1:0] center_col,
  output logic          frame_done,
  output logic          busy,
  output logic          sof_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int LW   = $clog2(WIN_LAT + 1);
  localparam int HALF = WIN / 2;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  // Edges left before the MAU window settles; nonzero means a window is in flight.
  logic [LW-1:0]   lat_cnt;

  logic pend;
  logic accept;
  logic hs;
  logic win_px;
  logic last_px;
  logic restart;

  assign pend    = lat_cnt != '0;
  assign accept  = s_valid && s_ready;
  assign hs      = m_valid && m_ready;
  assign win_px  = (row >= RW'(WIN - 1)) && (col >= CW'(WIN - 1));
  assign last_px = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign busy    = state != IDLE;

  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      IDLE:    s_ready = 1'b1;
      RUN:     s_ready = !pend && !(m_valid && !m_ready);
      DRAIN:   s_ready = 1'b0;
      default: s_ready = 1'b0;
    endcase
  end

  // IDLE swallows pixels until start-of-frame; those never reach the MAU.
  assign shift_en = accept && ((state != IDLE) || s_sof);

`ifdef WSC_ERR_CHECK_EN
  assign restart = accept && s_sof && (state == RUN);
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      lat_cnt    <= '0;
      m_valid    <= 1'b0;
      center_row <= '0;
      center_col <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      if (hs) m_valid <= 1'b0;
      if (pend) begin
        lat_cnt <= lat_cnt - LW'(1);
        if (lat_cnt == LW'(1)) m_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (shift_en) begin
            row   <= '0;
            col   <= CW'(1);
            state <= RUN;
          end
        end
        RUN: begin
          if (restart) begin
            sof_err <= 1'b1;
            m_valid <= 1'b0;
            lat_cnt <= '0;
            row     <= '0;
            col     <= CW'(1);
          end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (win_px) begin
              center_row <= row - RW'(HALF);
              center_col <= col - CW'(HALF);
              if (WIN_LAT == 1) m_valid <= 1'b1;
              else lat_cnt <= LW'(WIN_LAT - 1);
            end
            if (last_px) begin
              row   <= '0;
              col   <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Randomized bench for window_scan_ctrl: frame-index model plus raster-order scoreboard.
module tb_window_scan_ctrl;

  localparam int W    = 16;
  localparam int H    = 10;
  localparam int WL   = 2;
  localparam int NWIN = (W - 6) * (H - 6);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       s_sof = 1'b0;
  logic       shift_en;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [3:0] center_row;
  logic [3:0] center_col;
  logic       frame_done;
  logic       busy;
  logic       sof_err;

  always #5 clk = ~clk;

  window_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .WIN(7), .CW(4), .RW(4), .WIN_LAT(WL)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .shift_en(shift_en),
    .m_valid(m_valid), .m_ready(m_ready),
    .center_row(center_row), .center_col(center_col),
    .frame_done(frame_done), .busy(busy), .sof_err(sof_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: md 0=idle 1=run 2=drain; idx = pixels of frame accepted.
  int md = 0, idx = 0, wt = 0, mr = 0, mc = 0;
  bit mv = 0, efd = 0, eserr = 0;
  int k = 0, win_cnt = 0, fd_cnt = 0, serr_cnt = 0;
  int last_r = -1, last_c = -1, sent = 0;
  int mr_mode = 0;
  bit release_mr = 0;

  always @(posedge clk) begin
    #1;
    if (mr_mode == 0) m_ready = 1'b1;
    else if (mr_mode == 1) m_ready = 1'($urandom_range(1));
    else m_ready = release_mr;
  end

  always @(negedge clk) begin : mon
    bit er, es, hs, mhs;
    int r, c;
    if (reset) begin
      md = 0; idx = 0; wt = 0; mv = 0; mr = 0; mc = 0;
      efd = 0; eserr = 0; k = 0; win_cnt = 0;
    end
    er = (md == 0) ? 1'b1 : (md == 2) ? 1'b0 : (wt == 0 && !(mv && !m_ready));
    es = s_valid && er && (md != 0 || s_sof);
    chk("s_ready", s_ready, er);
    chk("shift_en", shift_en, es);
    chk("m_valid", m_valid, mv);
    if (mv) begin
      chk("center_row", center_row, mr);
      chk("center_col", center_col, mc);
    end
    chk("frame_done", frame_done, efd);
    chk("busy", busy, md != 0);
    chk("sof_err", sof_err, eserr);
    if (frame_done) begin
      fd_cnt++;
      chk("windows_per_frame", win_cnt, NWIN);
      win_cnt = 0;
      k = 0;
    end
    if (sof_err) serr_cnt++;
    hs = m_valid && m_ready;
    if (hs) begin
      chk("raster_row", center_row, 3 + k / (W - 6));
      chk("raster_col", center_col, 3 + k % (W - 6));
      k++;
      win_cnt++;
      last_r = center_row;
      last_c = center_col;
    end
    if (!reset) begin
      efd = 0;
      eserr = 0;
      mhs = mv && m_ready;
      if (mhs) mv = 0;
      if (wt > 0) begin
        wt--;
        if (wt == 0) mv = 1;
      end
      if (md == 2 && mhs) begin
        efd = 1;
        md = 0;
      end else if (es) begin
        if (md == 0) begin
          md = 1;
          idx = 1;
        end
`ifdef WSC_ERR_CHECK_EN
        else if (s_sof) begin
          eserr = 1; mv = 0; wt = 0; idx = 1; k = 0; win_cnt = 0;
        end
`endif
        else begin
          r = idx / W;
          c = idx % W;
          if (r >= 6 && c >= 6) begin
            mr = r - 3;
            mc = c - 3;
            if (WL == 1) mv = 1;
            else wt = WL - 1;
          end
          idx++;
          if (idx == W * H) md = 2;
        end
      end
    end
  end

  task automatic send_frame(input int npix, input int gap, input int sof2, input int rst_at);
    int cyc = 0;
    bit acc;
    sent = 0;
    s_sof = 1'b1;
    s_valid = ($urandom_range(99) >= gap);
    while (sent < npix && cyc < 20000) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) sent++;
      if (sent == rst_at) begin
        reset = 1'b1;
        s_valid = 1'b0;
        s_sof = 1'b0;
        return;
      end
      s_sof = (sent == 0) || (sent == sof2);
      s_valid = (sent < npix) && ($urandom_range(99) >= gap);
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    chk("send_complete", sent, npix);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (fd_cnt < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", fd_cnt, target);
  endtask

  task automatic first_win(input int exp_sent, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("first_win_after_pixels", sent, exp_sent);
    chk("first_center_row", center_row, 3);
    chk("first_center_col", center_col, 3);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        chk("hold_m_valid", m_valid, 1);
        chk("hold_row", center_row, 3);
        chk("hold_col", center_col, 3);
        chk("hold_s_ready", s_ready, 0);
        chk("hold_shift_en", shift_en, 0);
        @(negedge clk);
      end
      release_mr = 1'b1;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_center_row", center_row, 0);
    chk("rst_center_col", center_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_s_ready", s_ready, 1);
  endtask

  initial begin
    int f0, s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 reset = 1'b0;

    // continuous frame
    f0 = fd_cnt;
    fork
      send_frame(W * H, 0, -1, -1);
      first_win(6 * W + 7, 1'b0);
    join
    wait_done(f0 + 1);
    chk("last_center_row", last_r, 6);
    chk("last_center_col", last_c, 12);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("single_done_pulse", fd_cnt, f0 + 1);

    // pixels without sof dropped in IDLE
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_sof = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("nosof_busy", busy, 0);
    chk("nosof_m_valid", m_valid, 0);
    s_valid = 1'b0;

    // consumer stall on the first window
    mr_mode = 2;
    release_mr = 1'b0;
    f0 = fd_cnt;
    fork
      send_frame(W * H, 0, -1, -1);
      first_win(6 * W + 7, 1'b1);
    join
    wait_done(f0 + 1);
    mr_mode = 0;

    // random source gaps and consumer backpressure
    mr_mode = 1;
    f0 = fd_cnt;
    send_frame(W * H, 30, -1, -1);
    wait_done(f0 + 1);
    mr_mode = 0;
    repeat (2) @(posedge clk);

    // reset mid-frame at pixel (7,8)
    #1;
    send_frame(W * H, 0, -1, 7 * W + 8);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 reset = 1'b0;
    f0 = fd_cnt;
    send_frame(W * H, 20, -1, -1);
    wait_done(f0 + 1);

    // s_sof reasserted at pixel (4,5)
    f0 = fd_cnt;
    s0 = serr_cnt;
`ifdef WSC_ERR_CHECK_EN
    fork
      send_frame(4 * W + 5 + W * H, 0, 4 * W + 5, -1);
      first_win(4 * W + 5 + 6 * W + 7, 1'b0);
    join
    wait_done(f0 + 1);
    chk("sof_err_pulses", serr_cnt, s0 + 1);
`else
    send_frame(W * H, 0, 4 * W + 5, -1);
    wait_done(f0 + 1);
    chk("sof_err_pulses", serr_cnt, s0);
`endif
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
